// File: rtl/wb_stage.sv
// Writeback stage: M->W pipeline register, load lane extract/extend, result mux
// and retired-instruction counter.
module wb_stage #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  EnW,
   input  logic                  FlushW,
   input  logic                  ValidM,
   input  logic                  RegWriteM,
   input  logic [1:0]            ResultSrcM,
   input  logic [2:0]            funct3M,
   input  logic [4:0]            RdM,
   input  logic [DATA_WIDTH-1:0] ALUResultM,
   input  logic [DATA_WIDTH-1:0] ReadDataM,
   input  logic [DATA_WIDTH-1:0] PCPlus4M,
   output logic                  RegWriteW,
   output logic [4:0]            RdW,
   output logic [DATA_WIDTH-1:0] ResultW,
   output logic                  ValidW,
   output logic [31:0]           RetireCount
);

   localparam int unsigned CNT_W = 32;

   logic                  r_valid;
   logic                  r_regwrite;
   logic [1:0]            r_resultsrc;
   logic [2:0]            r_funct3;
   logic [4:0]            r_rd;
   logic [DATA_WIDTH-1:0] r_alu;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic [DATA_WIDTH-1:0] r_pc4;
   logic [CNT_W-1:0]      r_retire;

   logic [7:0]            w_byte;
   logic [15:0]           w_half;
   logic [DATA_WIDTH-1:0] w_result;

   // Pipeline register; a flush only kills valid/regwrite, data may go stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_valid     <= 1'b0;
         r_regwrite  <= 1'b0;
         r_resultsrc <= 2'b00;
         r_funct3    <= 3'b000;
         r_rd        <= 5'd0;
         r_alu       <= '0;
         r_rdata     <= '0;
         r_pc4       <= '0;
         r_retire    <= '0;
      end else begin
         if (r_valid && EnW && !FlushW) begin
            r_retire <= r_retire + CNT_W'(1);
         end
         if (FlushW) begin
            r_valid    <= 1'b0;
            r_regwrite <= 1'b0;
         end else if (EnW) begin
            r_valid     <= ValidM;
            r_regwrite  <= RegWriteM;
            r_resultsrc <= ResultSrcM;
            r_funct3    <= funct3M;
            r_rd        <= RdM;
            r_alu       <= ALUResultM;
            r_rdata     <= ReadDataM;
            r_pc4       <= PCPlus4M;
         end
      end
   end

   // Load lane select from the low address bits held in W.
   always_comb begin
      w_byte = r_rdata[7:0];
      case (r_alu[1:0])
         2'd1:    w_byte = r_rdata[15:8];
         2'd2:    w_byte = r_rdata[23:16];
         2'd3:    w_byte = r_rdata[31:24];
         default: w_byte = r_rdata[7:0];
      endcase
      w_half = r_alu[1] ? r_rdata[31:16] : r_rdata[15:0];
   end

   always_comb begin
      w_result = r_alu;
      case (r_resultsrc)
         2'b01: begin
            case (r_funct3)
               3'b000:  w_result = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
               3'b001:  w_result = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
               3'b100:  w_result = {{(DATA_WIDTH-8){1'b0}}, w_byte};
               3'b101:  w_result = {{(DATA_WIDTH-16){1'b0}}, w_half};
               default: w_result = r_rdata;
            endcase
         end
         2'b10:   w_result = r_pc4;
         default: w_result = r_alu;
      endcase
   end

   assign ValidW      = r_valid;
   assign RegWriteW   = r_regwrite & r_valid & (r_rd != 5'd0);
   assign RdW         = r_rd;
   assign ResultW     = w_result;
   assign RetireCount = r_retire;

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: expected W outputs queued at issue, popped
// one cycle later; retire count tracked by a small bench-side model.
module tb_wb_stage;

   localparam int unsigned DW = 32;

   logic          clk, rst, EnW, FlushW, ValidM, RegWriteM;
   logic [1:0]    ResultSrcM;
   logic [2:0]    funct3M;
   logic [4:0]    RdM;
   logic [DW-1:0] ALUResultM, ReadDataM, PCPlus4M;
   logic          RegWriteW, ValidW;
   logic [4:0]    RdW;
   logic [DW-1:0] ResultW;
   logic [31:0]   RetireCount;

   wb_stage #(.DATA_WIDTH(DW)) dut (
      .clk(clk), .rst(rst), .EnW(EnW), .FlushW(FlushW), .ValidM(ValidM),
      .RegWriteM(RegWriteM), .ResultSrcM(ResultSrcM), .funct3M(funct3M),
      .RdM(RdM), .ALUResultM(ALUResultM), .ReadDataM(ReadDataM),
      .PCPlus4M(PCPlus4M), .RegWriteW(RegWriteW), .RdW(RdW),
      .ResultW(ResultW), .ValidW(ValidW), .RetireCount(RetireCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        v;
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] res;
   } exp_t;

   typedef struct {
      logic [2:0]  f3;
      logic [1:0]  src;
      logic [31:0] alu;
      logic [31:0] res;
   } ld_vec_t;

   exp_t        sb[$];
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   logic        m_valid = 1'b0;
   logic [31:0] m_count = 32'd0;

   task automatic drive(input logic v, input logic rw, input logic [1:0] src,
                        input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] rdata,
                        input logic [31:0] pc4);
      ValidM = v; RegWriteM = rw; ResultSrcM = src; funct3M = f3; RdM = rd;
      ALUResultM = alu; ReadDataM = rdata; PCPlus4M = pc4;
   endtask

   // Advance one edge, updating the retire/valid model from the driven controls.
   task automatic tick();
      if (m_valid && EnW && !FlushW) m_count = m_count + 32'd1;
      if (FlushW) m_valid = 1'b0;
      else if (EnW) m_valid = ValidM;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t obs;
      rst = 1'b1; EnW = 1'b1; FlushW = 1'b0;
      drive(1'b1, 1'b1, 2'b10, 3'b000, 5'd9, 32'h1, 32'h2, 32'h3);
      repeat (2) @(posedge clk);
      #1;
      obs = {ValidW, RegWriteW, RdW, ResultW};
      n_vec++;
      if (obs !== '0) begin
         n_err++;
         $display("FAIL reset_outputs got=%h want=0", obs);
      end
      n_vec++;
      if (RetireCount !== 32'd0) begin
         n_err++;
         $display("FAIL reset_count got=%h want=0", RetireCount);
      end
      rst = 1'b0;
      m_valid = 1'b0; m_count = 32'd0;
   endtask

   task automatic test_loads();
      ld_vec_t tbl[13];
      exp_t    e, obs;
      tbl[0]  = '{3'b000, 2'b01, 32'h103, 32'hFFFFFF80};
      tbl[1]  = '{3'b101, 2'b01, 32'h102, 32'h000080FF};
      tbl[2]  = '{3'b001, 2'b01, 32'h102, 32'hFFFF80FF};
      tbl[3]  = '{3'b100, 2'b01, 32'h001, 32'h0000007F};
      tbl[4]  = '{3'b000, 2'b01, 32'h000, 32'h00000001};
      tbl[5]  = '{3'b000, 2'b01, 32'h002, 32'hFFFFFFFF};
      tbl[6]  = '{3'b001, 2'b01, 32'h103, 32'hFFFF80FF};
      tbl[7]  = '{3'b101, 2'b01, 32'h000, 32'h00007F01};
      tbl[8]  = '{3'b010, 2'b01, 32'h003, 32'h80FF7F01};
      tbl[9]  = '{3'b110, 2'b01, 32'h001, 32'h80FF7F01};
      tbl[10] = '{3'b000, 2'b00, 32'h1234, 32'h00001234};
      tbl[11] = '{3'b000, 2'b11, 32'hABCD0001, 32'hABCD0001};
      tbl[12] = '{3'b000, 2'b10, 32'h0, 32'h00001000};
      for (int i = 0; i < 13; i++) begin
         drive(1'b1, 1'b1, tbl[i].src, tbl[i].f3, 5'(5 + i), tbl[i].alu,
               32'h80FF7F01, 32'h1000);
         sb.push_back('{1'b1, 1'b1, 5'(5 + i), tbl[i].res});
         tick();
         e = sb.pop_front();
         obs = {ValidW, RegWriteW, RdW, ResultW};
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL load_%0d got v=%b rw=%b rd=%0d res=%h want v=%b rw=%b rd=%0d res=%h",
                     i, obs.v, obs.rw, obs.rd, obs.res, e.v, e.rw, e.rd, e.res);
         end
         n_vec++;
         if (RetireCount !== m_count) begin
            n_err++;
            $display("FAIL load_count_%0d got=%0d want=%0d", i, RetireCount, m_count);
         end
      end
   endtask

   task automatic test_x0_pc4();
      exp_t        e, obs;
      logic [31:0] c0;
      drive(1'b1, 1'b1, 2'b10, 3'b000, 5'd0, 32'h99, 32'h0, 32'h44);
      sb.push_back('{1'b1, 1'b0, 5'd0, 32'h44});
      tick();
      c0 = m_count;
      e = sb.pop_front();
      obs = {ValidW, RegWriteW, RdW, ResultW};
      n_vec++;
      if (obs !== e) begin
         n_err++;
         $display("FAIL x0_pc4 got=%h want=%h", obs, e);
      end
      drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
      tick();
      n_vec++;
      if (RetireCount !== c0 + 32'd1) begin
         n_err++;
         $display("FAIL x0_retire got=%0d want=%0d", RetireCount, c0 + 32'd1);
      end
   endtask

   task automatic test_stall_flush();
      exp_t        e, obs;
      logic [31:0] c0;
      drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd7, 32'h55AA, 32'h0, 32'h0);
      sb.push_back('{1'b1, 1'b1, 5'd7, 32'h55AA});
      tick();
      e = sb.pop_front();
      c0 = m_count;
      EnW = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b1, 2'b10, 3'(i), 5'(20 + i), 32'(i), 32'hDEAD, 32'hBEEF);
         tick();
         obs = {ValidW, RegWriteW, RdW, ResultW};
         n_vec++;
         if (obs !== e) begin
            n_err++;
            $display("FAIL stall_hold_%0d got=%h want=%h", i, obs, e);
         end
         n_vec++;
         if (RetireCount !== c0) begin
            n_err++;
            $display("FAIL stall_count_%0d got=%0d want=%0d", i, RetireCount, c0);
         end
      end
      FlushW = 1'b1;
      tick();
      n_vec++;
      if ({ValidW, RegWriteW} !== 2'b00) begin
         n_err++;
         $display("FAIL flush_valid got=%b want=00", {ValidW, RegWriteW});
      end
      n_vec++;
      if (RetireCount !== c0) begin
         n_err++;
         $display("FAIL flush_count got=%0d want=%0d", RetireCount, c0);
      end
      FlushW = 1'b0; EnW = 1'b1;
   endtask

   task automatic test_wrap_reset();
      exp_t obs;
      drive(1'b1, 1'b1, 2'b00, 3'b000, 5'd3, 32'h10, 32'h0, 32'h0);
      tick();
      force dut.r_retire = 32'hFFFFFFFF;
      #1;
      release dut.r_retire;
      m_count = 32'hFFFFFFFF;
      tick();
      n_vec++;
      if (RetireCount !== 32'd0) begin
         n_err++;
         $display("FAIL wrap got=%h want=0", RetireCount);
      end
      // Reset asserted mid-stall, between edges.
      EnW = 1'b0;
      #2 rst = 1'b1;
      #1;
      obs = {ValidW, RegWriteW, RdW, ResultW};
      n_vec++;
      if (obs !== '0 || RetireCount !== 32'd0) begin
         n_err++;
         $display("FAIL async_reset got=%h cnt=%h want=0", obs, RetireCount);
      end
      rst = 1'b0;
      m_valid = 1'b0; m_count = 32'd0;
      EnW = 1'b1;
      drive(1'b1, 1'b1, 2'b10, 3'b000, 5'd9, 32'h0, 32'h0, 32'h200);
      sb.push_back('{1'b1, 1'b1, 5'd9, 32'h200});
      tick();
      obs = {ValidW, RegWriteW, RdW, ResultW};
      n_vec++;
      if (obs !== sb[0] || RetireCount !== 32'd0) begin
         n_err++;
         $display("FAIL post_reset got=%h cnt=%0d want=%h cnt=0", obs, RetireCount, sb[0]);
      end
      void'(sb.pop_front());
      drive(1'b0, 1'b0, 2'b00, 3'b000, 5'd0, 32'h0, 32'h0, 32'h0);
      tick();
      n_vec++;
      if (RetireCount !== 32'd1) begin
         n_err++;
         $display("FAIL post_reset_retire got=%0d want=1", RetireCount);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_loads();
      test_x0_pc4();
      test_stall_flush();
      test_wrap_reset();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
